tea_decipher_stream: RTL and testbench



---
 rtl/tea_pkg.sv | 22 ++
 rtl/decipher.sv | 73 +++++++
 rtl/tea_decipher_stream.sv | 146 ++++++++++++++
 tb/tb_tea_decipher_stream.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared constants for the TEA decipher stream front-end and its core.
package tea_pkg;

  localparam logic [31:0] DELTA_DEFAULT = 32'h9e3779b9;
  localparam logic [31:0] SUM_INIT      = 32'hC6EF3720;

  // Word index of each key slice inside the packed 128-bit key.
  localparam int unsigned KEY_K0_IDX = 3;
  localparam int unsigned KEY_K1_IDX = 2;
  localparam int unsigned KEY_K2_IDX = 1;
  localparam int unsigned KEY_K3_IDX = 0;

  typedef enum logic [2:0] {
    LOAD_V0 = 3'd0,
    LOAD_V1 = 3'd1,
    ARM     = 3'd2,
    RUN     = 3'd3,
    OUT_W0  = 3'd4,
    OUT_W1  = 3'd5
  } state_e;

endpackage

// File: rtl/decipher.sv
// Iterative TEA decipher core: one full round per clock while iStart is high,
// reloads the block and sum while iStart is low.
module decipher import tea_pkg::*; #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter logic [31:0] DELTA        = DELTA_DEFAULT,
  parameter int unsigned ROUND_NUMBER = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iStart,
  input  logic [WORD_SIZE-1:0] iV0,
  input  logic [WORD_SIZE-1:0] iV1,
  input  logic [WORD_SIZE-1:0] iK0,
  input  logic [WORD_SIZE-1:0] iK1,
  input  logic [WORD_SIZE-1:0] iK2,
  input  logic [WORD_SIZE-1:0] iK3,
  output logic [WORD_SIZE-1:0] oC0,
  output logic [WORD_SIZE-1:0] oC1,
  output logic                 oDone
);

  localparam int unsigned RCW = $clog2(ROUND_NUMBER + 1);
  localparam logic [WORD_SIZE-1:0] DELTA_W = WORD_SIZE'(DELTA);
  localparam logic [WORD_SIZE-1:0] SUM_START =
    (ROUND_NUMBER == 32 && DELTA == DELTA_DEFAULT) ? WORD_SIZE'(SUM_INIT)
                                                   : WORD_SIZE'(DELTA * ROUND_NUMBER);

  logic [WORD_SIZE-1:0] v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [WORD_SIZE-1:0] v0_rnd, v1_rnd;
  logic [RCW-1:0]       rnd_q, rnd_d;
  logic                 done;

  assign done = (rnd_q == RCW'(ROUND_NUMBER));

  always_comb begin
    v0_d   = v0_q;
    v1_d   = v1_q;
    sum_d  = sum_q;
    rnd_d  = rnd_q;
    v1_rnd = v1_q - (((v0_q << 4) + iK2) ^ (v0_q + sum_q) ^ ((v0_q >> 5) + iK3));
    v0_rnd = v0_q - (((v1_rnd << 4) + iK0) ^ (v1_rnd + sum_q) ^ ((v1_rnd >> 5) + iK1));
    if (!iStart) begin
      v0_d  = iV0;
      v1_d  = iV1;
      sum_d = SUM_START;
      rnd_d = '0;
    end else if (!done) begin
      v0_d  = v0_rnd;
      v1_d  = v1_rnd;
      sum_d = sum_q - DELTA_W;
      rnd_d = rnd_q + RCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q  <= '0;
      v1_q  <= '0;
      sum_q <= '0;
      rnd_q <= '0;
    end else begin
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      sum_q <= sum_d;
      rnd_q <= rnd_d;
    end
  end

  assign oC0   = v0_q;
  assign oC1   = v1_q;
  assign oDone = done;

endmodule

// File: rtl/tea_decipher_stream.sv
// Word-stream wrapper around the decipher core: collects V0/V1, runs one block,
// and emits P0/P1 over valid/ready while holding a key loaded between blocks.
module tea_decipher_stream import tea_pkg::*; #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter logic [31:0] DELTA        = DELTA_DEFAULT,
  parameter int unsigned ROUND_NUMBER = 32,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iKeyLoad,
  input  logic [4*WORD_SIZE-1:0] iKey,
  output logic                   oKeyValid,
  input  logic                   iInValid,
  input  logic [WORD_SIZE-1:0]   iInData,
  output logic                   oInReady,
  output logic                   oOutValid,
  output logic [WORD_SIZE-1:0]   oOutData,
  input  logic                   iOutReady,
  output logic                   oBusy,
  output logic [CNT_W-1:0]       oBlockCount
);

  state_e                 state_q, state_d;
  logic [4*WORD_SIZE-1:0] key_q, key_d;
  logic                   key_valid_q, key_valid_d;
  logic [WORD_SIZE-1:0]   v0_q, v0_d, v1_q, v1_d, p0_q, p0_d, p1_q, p1_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0]   out_data_q, out_data_d;
  logic                   busy_q, busy_d, start_q, start_d;
  logic [WORD_SIZE-1:0]   core_c0, core_c1;
  logic                   core_done;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      LOAD_V0: begin
        if (iKeyLoad) begin
          key_d       = iKey;
          key_valid_d = 1'b1;
        end
        if (iInValid && in_ready_q) begin
          v0_d    = iInData;
          state_d = LOAD_V1;
        end
      end
      LOAD_V1: begin
        if (iInValid && in_ready_q) begin
          v1_d    = iInData;
          state_d = ARM;
        end
      end
      ARM: state_d = RUN;
      RUN: begin
        if (core_done) begin
          p0_d    = core_c0;
          p1_d    = core_c1;
          state_d = OUT_W0;
        end
      end
      OUT_W0: if (iOutReady) state_d = OUT_W1;
      OUT_W1: begin
        if (iOutReady) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = LOAD_V0;
        end
      end
      default: state_d = LOAD_V0;
    endcase

    // Handshake outputs are registered from the next state.
    in_ready_d  = (state_d == LOAD_V0) ? key_valid_d : (state_d == LOAD_V1);
    out_valid_d = (state_d == OUT_W0) || (state_d == OUT_W1);
    out_data_d  = (state_d == OUT_W0) ? p0_d :
                  (state_d == OUT_W1) ? p1_d : '0;
    busy_d      = (state_d != LOAD_V0);
    start_d     = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_V0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      v0_q        <= '0;
      v1_q        <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
    end
  end

  decipher #(
    .WORD_SIZE   (WORD_SIZE),
    .DELTA       (DELTA),
    .ROUND_NUMBER(ROUND_NUMBER)
  ) u_decipher (
    .clk   (clk),
    .rst   (rst),
    .iStart(start_q),
    .iV0   (v0_q),
    .iV1   (v1_q),
    .iK0   (key_q[KEY_K0_IDX*WORD_SIZE +: WORD_SIZE]),
    .iK1   (key_q[KEY_K1_IDX*WORD_SIZE +: WORD_SIZE]),
    .iK2   (key_q[KEY_K2_IDX*WORD_SIZE +: WORD_SIZE]),
    .iK3   (key_q[KEY_K3_IDX*WORD_SIZE +: WORD_SIZE]),
    .oC0   (core_c0),
    .oC1   (core_c1),
    .oDone (core_done)
  );

  assign oKeyValid   = key_valid_q;
  assign oInReady    = in_ready_q;
  assign oOutValid   = out_valid_q;
  assign oOutData    = out_data_q;
  assign oBusy       = busy_q;
  assign oBlockCount = cnt_q;

endmodule

// File: tb/tb_tea_decipher_stream.sv
// Randomised and directed bench for tea_decipher_stream against a plain TEA model.
module tb_tea_decipher_stream;

  logic         clk, rst;
  logic         iKeyLoad;
  logic [127:0] iKey;
  logic         oKeyValid;
  logic         iInValid;
  logic [31:0]  iInData;
  logic         oInReady;
  logic         oOutValid;
  logic [31:0]  oOutData;
  logic         iOutReady;
  logic         oBusy;
  logic [15:0]  oBlockCount;

  int n_cmp = 0;
  int n_fail = 0;
  int rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random

  tea_decipher_stream dut (
    .clk(clk), .rst(rst), .iKeyLoad(iKeyLoad), .iKey(iKey), .oKeyValid(oKeyValid),
    .iInValid(iInValid), .iInData(iInData), .oInReady(oInReady),
    .oOutValid(oOutValid), .oOutData(oOutData), .iOutReady(iOutReady),
    .oBusy(oBusy), .oBlockCount(oBlockCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] tea_dec(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [127:0] k);
    logic [31:0] y, z, sum;
    y = c0; z = c1; sum = 32'h9e3779b9 * 32'd32;
    for (int r = 0; r < 32; r++) begin
      z = z - (((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]));
      y = y - (((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]));
      sum = sum - 32'h9e3779b9;
    end
    return {y, z};
  endfunction

  function automatic logic [63:0] tea_enc(input logic [31:0] p0, input logic [31:0] p1,
                                          input logic [127:0] k);
    logic [31:0] y, z, sum;
    y = p0; z = p1; sum = 32'd0;
    for (int r = 0; r < 32; r++) begin
      sum = sum + 32'h9e3779b9;
      y = y + (((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  // Behavioural model state, advanced at each negedge for the upcoming posedge.
  logic [127:0] m_key;
  logic         m_key_valid, m_busy, m_in_block, m_out_seen, m_out_idx;
  logic [31:0]  m_v0;
  logic [15:0]  m_cnt;
  logic [31:0]  exp_q[$];
  int           m_lat, first_lat;

  initial first_lat = 0;

  always @(negedge clk) begin
    logic [63:0] pt;
    if (rst) begin
      m_key = '0; m_key_valid = 0; m_busy = 0; m_in_block = 0;
      m_out_seen = 0; m_out_idx = 0; m_cnt = '0; m_lat = 0;
      exp_q.delete();
    end else begin
      chk("block_count", 64'(oBlockCount), 64'(m_cnt));
      chk("busy", 64'(oBusy), 64'(m_busy));
      chk("key_valid", 64'(oKeyValid), 64'(m_key_valid));
      if (m_in_block)      chk("in_ready_block", 64'(oInReady), 64'(0));
      else if (!m_busy)    chk("in_ready_v0", 64'(oInReady), 64'(m_key_valid));
      else                 chk("in_ready_v1", 64'(oInReady), 64'(1));
      if (m_in_block && !m_out_seen) begin
        m_lat++;
        if (oOutValid) begin
          m_out_seen = 1;
          chk("latency_bound", 64'(m_lat <= 388), 64'(1));
          if (first_lat == 0) first_lat = m_lat;
          else chk("latency_fixed", 64'(m_lat), 64'(first_lat));
        end else if (m_lat > 400) begin
          chk("latency_timeout", 64'(m_lat), 64'(388));
          m_out_seen = 1;
        end
      end
      if (m_out_seen && exp_q.size() > 0) chk("out_valid_held", 64'(oOutValid), 64'(1));
      if (oOutValid) begin
        if (exp_q.size() == 0) chk("out_unexpected", 64'(oOutValid), 64'(0));
        else chk("out_data", 64'(oOutData), 64'(exp_q[0]));
      end
      if (iKeyLoad && !m_busy) begin
        m_key = iKey;
        m_key_valid = 1;
      end
      if (iInValid && oInReady) begin
        if (!m_busy) begin
          m_v0 = iInData;
          m_busy = 1;
        end else begin
          pt = tea_dec(m_v0, iInData, m_key);
          exp_q.push_back(pt[63:32]);
          exp_q.push_back(pt[31:0]);
          m_in_block = 1; m_lat = 0; m_out_seen = 0;
        end
      end
      if (oOutValid && iOutReady && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        m_out_idx = ~m_out_idx;
        if (!m_out_idx) begin
          m_cnt++; m_busy = 0; m_in_block = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: iOutReady = 1'b1;
        1: iOutReady = 1'b0;
        default: iOutReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit keep, input bit ld,
                           input logic [127:0] k);
    bit ok;
    ok = 0;
    iInValid = 1'b1; iInData = w;
    if (ld) begin iKeyLoad = 1'b1; iKey = k; end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (oInReady) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    iKeyLoad = 1'b0;
    if (!keep) iInValid = 1'b0;
  endtask

  task automatic key_pulse(input logic [127:0] k);
    iKey = k; iKeyLoad = 1'b1;
    @(posedge clk); #1;
    iKeyLoad = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!m_busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (oOutValid) begin ok = 1; break; end
    end
    if (!ok) chk("out_valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key_valid"}, 64'(oKeyValid), 64'(0));
    chk({tag, "_out_valid"}, 64'(oOutValid), 64'(0));
    chk({tag, "_out_data"}, 64'(oOutData), 64'(0));
    chk({tag, "_count"}, 64'(oBlockCount), 64'(0));
    chk({tag, "_in_ready"}, 64'(oInReady), 64'(0));
    chk({tag, "_busy"}, 64'(oBusy), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] p, c;
    logic [127:0] k;
    int bad;
    rst = 1'b1; iKeyLoad = 0; iKey = '0; iInValid = 0; iInData = '0; iOutReady = 1'b1;

    chk("model_ka", tea_dec(32'h41ea3a0a, 32'h94baa940, 128'h0), 64'h0);
    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom};
      c = tea_enc(p[63:32], p[31:0], k);
      chk("model_roundtrip", tea_dec(c[63:32], c[31:0], k), p);
    end

    repeat (3) @(posedge clk);
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // No key loaded: input must be refused.
    iInValid = 1'b1; iInData = 32'hdead_beef; bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (oInReady) bad++;
    end
    chk("nokey_in_ready", 64'(bad), 64'(0));
    @(posedge clk); #1;
    iInValid = 1'b0;
    key_pulse(128'h0);
    @(negedge clk);
    chk("keyload_valid", 64'(oKeyValid), 64'(1));
    chk("keyload_ready", 64'(oInReady), 64'(1));
    @(posedge clk); #1;

    // Known-answer block.
    send_word(32'h41ea3a0a, 0, 0, '0);
    send_word(32'h94baa940, 0, 0, '0);
    wait_out_valid(500);
    chk("ka_p0", 64'(oOutData), 64'(0));
    wait_idle(500);
    chk("ka_count", 64'(oBlockCount), 64'(1));

    // Output back-pressure.
    rdy_mode = 1; cycles(1);
    send_word(32'h41ea3a0a, 0, 0, '0);
    send_word(32'h94baa940, 0, 0, '0);
    wait_out_valid(500);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!oOutValid || oOutData != 32'h0) bad++;
    end
    chk("bp_hold", 64'(bad), 64'(0));
    rdy_mode = 0;
    wait_idle(100);
    chk("bp_count", 64'(oBlockCount), 64'(2));
    chk("bp_idle_busy", 64'(oBusy), 64'(0));
    chk("bp_idle_ready", 64'(oInReady), 64'(1));

    // Key load during RUN is ignored, also for the following block.
    send_word(32'h41ea3a0a, 0, 0, '0);
    send_word(32'h94baa940, 0, 0, '0);
    cycles(10);
    key_pulse(128'h1);
    wait_idle(500);
    chk("midkey_count", 64'(oBlockCount), 64'(3));
    send_word(32'h41ea3a0a, 0, 0, '0);
    send_word(32'h94baa940, 0, 0, '0);
    wait_out_valid(500);
    chk("midkey_next_p0", 64'(oOutData), 64'(0));
    wait_idle(500);
    chk("midkey_next_count", 64'(oBlockCount), 64'(4));

    // Asynchronous reset while the core is running.
    send_word(32'h41ea3a0a, 0, 0, '0);
    send_word(32'h94baa940, 0, 0, '0);
    cycles(20);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    key_pulse(128'h0);
    send_word(32'h41ea3a0a, 0, 0, '0);
    send_word(32'h94baa940, 0, 0, '0);
    wait_idle(500);
    chk("rst_rerun_count", 64'(oBlockCount), 64'(1));

    // Back-to-back blocks with valid and ready held high.
    for (int b = 0; b < 3; b++) begin
      send_word(32'h41ea3a0a, 1, 0, '0);
      send_word(32'h94baa940, (b < 2), 0, '0);
    end
    wait_idle(1000);
    chk("b2b_count", 64'(oBlockCount), 64'(4));

    // Random keys, data, gaps and output back-pressure.
    rdy_mode = 2;
    key_pulse({$urandom, $urandom, $urandom, $urandom});
    for (int b = 0; b < 20; b++) begin
      cycles($urandom_range(0, 2));
      k = {$urandom, $urandom, $urandom, $urandom};
      send_word($urandom, 0, ($urandom_range(0, 2) == 0), k);
      if ($urandom_range(0, 3) == 0) key_pulse(~k);
      send_word($urandom, 0, 0, '0);
    end
    wait_idle(5000);
    rdy_mode = 0;
    chk("rand_count", 64'(oBlockCount), 64'(24));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
